// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative multiply/divide unit with HI/LO registers for the EXE stage.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous reset, active low
//   start      EXE-stage instruction valid
//   op         000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 NONE
//   flush      kill the EXE instruction and any operation in progress
//   src_a      rs operand (dividend / multiplicand / MTHI-MTLO data)
//   src_b      rt operand (divisor / multiplier)
//   stall_out  combinational pipeline hold request
//   done       registered one-cycle pulse when a MUL/DIV result lands in HI/LO
//   hi, lo     HI and LO registers
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting; accepts MUL/DIV, performs MTHI/MTLO in place
// CALC  | WIDTH iterations, one result bit per cycle on magnitudes
// FIX   | sign correction / special cases, commit to HI/LO on exit

module exe_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic             flush,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             stall_out,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   state_t             r_state;
   logic               r_done;
   logic [CW-1:0]      r_cnt;
   logic [2:0]         r_op;
   logic [WIDTH-1:0]   r_mag_b;
   logic [WIDTH-1:0]   r_src_a;
   logic [2*WIDTH-1:0] r_acc;
   logic               r_neg_a;
   logic               r_neg_b;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic               w_idle_go;
   logic               w_is_muldiv;
   logic               w_signed_in;
   logic               w_accept;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic               w_is_div;
   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_mul_next;
   logic [WIDTH:0]     w_div_shift;
   logic [WIDTH:0]     w_div_trial;
   logic [2*WIDTH-1:0] w_div_next;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_res_hi;
   logic [WIDTH-1:0]   w_res_lo;

   // A finished instruction still sits in EXE during its done cycle, so start is ignored then.
   assign w_idle_go   = (r_state == ST_IDLE) && start && !flush && !r_done;
   assign w_is_muldiv = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   assign w_signed_in = (op == OP_MULT) || (op == OP_DIV);
   assign w_accept    = w_idle_go && w_is_muldiv;

   // Two's-complement negate of the most negative value yields 2^(WIDTH-1) as an unsigned magnitude.
   assign w_mag_a = (w_signed_in && src_a[WIDTH-1]) ? (~src_a + 1'b1) : src_a;
   assign w_mag_b = (w_signed_in && src_b[WIDTH-1]) ? (~src_b + 1'b1) : src_b;

   assign w_is_div = (r_op == OP_DIV) || (r_op == OP_DIVU);

   // Multiply: acc = {partial product, remaining multiplier bits}; add then shift right.
   assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag_b} : '0);
   assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

   // Divide: acc = {partial remainder, dividend bits shifting into quotient bits}.
   assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_div_trial = w_div_shift - {1'b0, r_mag_b};
   assign w_div_next  = w_div_trial[WIDTH]
                      ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                      : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

   assign w_prod = ((r_op == OP_MULT) && (r_neg_a ^ r_neg_b)) ? (~r_acc + 1'b1) : r_acc;
   assign w_quo  = ((r_op == OP_DIV) && (r_neg_a ^ r_neg_b))
                 ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
   assign w_rem  = ((r_op == OP_DIV) && r_neg_a)
                 ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

   // Signed overflow needs no special case: |MIN| / 1 gives 2^(WIDTH-1) with equal signs, remainder 0.
   always_comb begin
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
      if (w_is_div) begin
         if (r_mag_b == '0) begin
            w_res_hi = r_src_a;
            w_res_lo = '1;
         end else begin
            w_res_hi = w_rem;
            w_res_lo = w_quo;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_done  <= 1'b0;
         r_cnt   <= '0;
         r_op    <= '0;
         r_mag_b <= '0;
         r_src_a <= '0;
         r_acc   <= '0;
         r_neg_a <= 1'b0;
         r_neg_b <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state <= ST_CALC;
                  r_cnt   <= '0;
                  r_op    <= op;
                  r_mag_b <= w_mag_b;
                  r_src_a <= src_a;
                  r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
                  r_neg_a <= w_signed_in && src_a[WIDTH-1];
                  r_neg_b <= w_signed_in && src_b[WIDTH-1];
               end else if (w_idle_go && (op == OP_MTHI)) begin
                  r_hi <= src_a;
               end else if (w_idle_go && (op == OP_MTLO)) begin
                  r_lo <= src_a;
               end
            end
            ST_CALC: begin
               if (flush) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_acc <= w_is_div ? w_div_next : w_mul_next;
                  if (r_cnt == CW'(WIDTH - 1)) begin
                     r_state <= ST_FIX;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            ST_FIX: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               if (!flush) begin
                  r_hi   <= w_res_hi;
                  r_lo   <= w_res_lo;
                  r_done <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign stall_out = rst && ((r_state != ST_IDLE) || w_accept);
   assign done      = r_done;
   assign hi        = r_hi;
   assign lo        = r_lo;

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv at WIDTH=32. Inputs change and outputs are sampled
// around the falling edge; expected values are hand-computed constants.

module tb_exe_muldiv;

   localparam int W = 32;

   localparam logic [2:0] OP_NONE  = 3'b000;
   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [2:0]   op;
   logic         flush;
   logic [W-1:0] src_a;
   logic [W-1:0] src_b;
   logic         stall_out;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int n_tests = 0;
   int n_fail  = 0;

   exe_muldiv #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .flush     (flush),
      .src_a     (src_a),
      .src_b     (src_b),
      .stall_out (stall_out),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Launch a MUL/DIV, scramble operands after the accept edge, observe 40 cycles.
   task automatic run_md(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit hold,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo);
      int n_stall = 0;
      int n_done  = 0;
      int lat     = -1;
      bit seen    = 1'b0;
      logic [W-1:0] got_hi = '0;
      logic [W-1:0] got_lo = '0;
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      for (int k = 0; k < 40; k++) begin
         if (k > 0) begin
            @(negedge clk);
            src_a = 32'hDEAD_BEEF;
            src_b = 32'h0000_1234;
            if (!hold || seen) start = 1'b0;
         end
         #1;
         if (stall_out) n_stall++;
         if (done) begin
            n_done++;
            if (!seen) lat = k;
            seen   = 1'b1;
            got_hi = hi;
            got_lo = lo;
         end
      end
      start = 1'b0;
      op    = OP_NONE;
      chk({tag, " stall_cycles"}, 64'(n_stall), 64'd34);
      chk({tag, " done_count"},   64'(n_done),  64'd1);
      chk({tag, " latency"},      64'(lat),     64'd34);
      chk({tag, " hi"},           64'(got_hi),  64'(ehi));
      chk({tag, " lo"},           64'(got_lo),  64'(elo));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_done;
      rst = 1'b0; start = 1'b0; op = OP_NONE; flush = 1'b0; src_a = '0; src_b = '0;

      // Reset state; stall must stay low while in reset even with a MUL request.
      #12;
      start = 1'b1; op = OP_MULT; src_a = 32'd3; src_b = 32'd4;
      #1;
      chk("rst stall", 64'(stall_out), 64'd0);
      chk("rst done",  64'(done),      64'd0);
      chk("rst hi",    64'(hi),        64'd0);
      chk("rst lo",    64'(lo),        64'd0);
      start = 1'b0; op = OP_NONE;
      @(negedge clk);
      rst = 1'b1;

      // MTLO: single cycle, no stall, lo written at the same edge.
      @(negedge clk);
      start = 1'b1; op = OP_MTLO; src_a = 32'h1234_5678;
      #1;
      chk("mtlo stall", 64'(stall_out), 64'd0);
      @(posedge clk); #1;
      chk("mtlo lo",    64'(lo),        64'h1234_5678);
      chk("mtlo stall2", 64'(stall_out), 64'd0);
      chk("mtlo done",  64'(done),      64'd0);
      @(negedge clk);
      start = 1'b0; op = OP_NONE;

      run_md("mult -2*3",  OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_md("multu",      OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 32'h0000_0002, 32'hFFFF_FFFA);
      run_md("div -7/2",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_md("divu 7/0",   OP_DIVU,  32'h0000_0007, 32'h0000_0000, 1'b0, 32'h0000_0007, 32'hFFFF_FFFF);
      run_md("div ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000);
      run_md("div 100/-7", OP_DIV,   32'd100,       32'hFFFF_FFF9, 1'b0, 32'h0000_0002, 32'hFFFF_FFF2);

      // DIVU 100/3 flushed in CALC cycle 10: prior hi=2, lo=0xFFFFFFF2 must survive.
      @(negedge clk);
      start = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd3;
      #1;
      chk("flush accept stall", 64'(stall_out), 64'd1);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start = 1'b0; op = OP_NONE;
         if (k == 10) flush = 1'b1;
      end
      #1;
      chk("flush cycle stall", 64'(stall_out), 64'd1);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flush after stall", 64'(stall_out), 64'd0);
      n_done = 0;
      for (int k = 0; k < 40; k++) begin
         if (done || stall_out) n_done++;
         @(negedge clk); #1;
      end
      chk("flush no done/stall", 64'(n_done), 64'd0);
      chk("flush hi kept", 64'(hi), 64'h0000_0002);
      chk("flush lo kept", 64'(lo), 64'hFFFF_FFF2);

      // start held through the done cycle: exactly one result, no relaunch.
      run_md("multu 5x5 hold", OP_MULTU, 32'd5, 32'd5, 1'b1, 32'd0, 32'd25);

      // flush with start in IDLE: no MTHI write, no accept.
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = OP_MTHI; src_a = 32'h55;
      #1;
      chk("idle flush mthi stall", 64'(stall_out), 64'd0);
      @(negedge clk);
      op = OP_MULT; src_a = 32'd3; src_b = 32'd3;
      #1;
      chk("idle flush mult stall", 64'(stall_out), 64'd0);
      chk("idle flush hi", 64'(hi), 64'd0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0; op = OP_NONE;
      #1;
      chk("idle flush no accept", 64'(stall_out), 64'd0);

      // Asynchronous reset in CALC cycle 5.
      @(negedge clk);
      start = 1'b1; op = OP_MULT; src_a = 32'd7; src_b = 32'd9;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         start = 1'b0; op = OP_NONE;
      end
      #2;
      rst = 1'b0;
      #1;
      chk("async rst hi",    64'(hi),        64'd0);
      chk("async rst lo",    64'(lo),        64'd0);
      chk("async rst stall", 64'(stall_out), 64'd0);
      start = 1'b1; op = OP_DIVU;
      n_done = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         if (done || stall_out) n_done++;
      end
      chk("in rst no done/stall", 64'(n_done), 64'd0);

      // Release and issue MTHI at the first edge.
      @(negedge clk);
      rst = 1'b1; start = 1'b1; op = OP_MTHI; src_a = 32'hA;
      #1;
      chk("post rst mthi stall", 64'(stall_out), 64'd0);
      @(posedge clk); #1;
      chk("post rst mthi hi", 64'(hi), 64'h0000_000A);
      chk("post rst lo",      64'(lo), 64'd0);
      @(negedge clk);
      start = 1'b0; op = OP_NONE;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
